// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and default widths for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int MAX_ADDR_W = 8;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  is_load;
    logic [MAX_ADDR_W-1:0] dest;
  } slot_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: youngest-match forwarding mux and load-use detection for one operand
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter bit ZERO_REG   = 1'b0,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  slot_t [DEPTH-1:0]        slots,
  input  logic  [ADDR_W-1:0]       src,
  input  logic                     used,
  input  logic  [DATA_W-1:0]       rf_data,
  input  logic  [DEPTH*DATA_W-1:0] stage_result,
  output logic  [SEL_W-1:0]        sel,
  output logic  [DATA_W-1:0]       data,
  output logic                     load_hazard
);
  logic is_zero;
  assign is_zero = ZERO_REG && (src == '0);
  // scan oldest to youngest so the youngest match overwrites; a not-yet-ready load keeps register-file data
  always_comb begin
    sel = SEL_W'(FWD_RF);
    data = rf_data;
    load_hazard = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (used && !is_zero && slots[k].valid && slots[k].reg_write &&
          slots[k].dest == MAX_ADDR_W'(src)) begin
        sel = SEL_W'(k+1);
        load_hazard = slots[k].is_load && (k < LOAD_READY);
        data = load_hazard ? rf_data : stage_result[k*DATA_W +: DATA_W];
      end
    end
    data = is_zero ? '0 : data;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: scoreboard of in-flight instructions driving forwarding, load-use stalls, flush and freeze
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter bit ZERO_REG   = 1'b0,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic                    id_reg_write,
  input  logic                    id_mem_read,
  input  logic [ADDR_W-1:0]       id_dest,
  input  logic [ADDR_W-1:0]       id_src1,
  input  logic [ADDR_W-1:0]       id_src2,
  input  logic                    id_src1_used,
  input  logic                    id_src2_used,
  input  logic [DATA_W-1:0]       rf_data1,
  input  logic [DATA_W-1:0]       rf_data2,
  input  logic [DEPTH*DATA_W-1:0] stage_result,
  input  logic                    mem_busy,
  input  logic                    flush,
  output logic [DATA_W-1:0]       op1,
  output logic [DATA_W-1:0]       op2,
  output logic [SEL_W-1:0]        fwd_sel1,
  output logic [SEL_W-1:0]        fwd_sel2,
  output logic                    stall,
  output logic                    freeze,
  output logic                    kill_id,
  output logic [15:0]             stall_count
);
  slot_t [DEPTH-1:0] slots_q, slots_d;
  logic [15:0] stall_count_q;
  logic hz1, hz2;

  fwd_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY),
               .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)) u_fwd1 (
    .slots(slots_q), .src(id_src1), .used(id_src1_used), .rf_data(rf_data1),
    .stage_result(stage_result), .sel(fwd_sel1), .data(op1), .load_hazard(hz1)
  );

  fwd_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY),
               .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)) u_fwd2 (
    .slots(slots_q), .src(id_src2), .used(id_src2_used), .rf_data(rf_data2),
    .stage_result(stage_result), .sel(fwd_sel2), .data(op2), .load_hazard(hz2)
  );

  assign stall = id_valid && (hz1 || hz2) && !flush;
  assign kill_id = flush;
  assign freeze = mem_busy;
  assign stall_count = stall_count_q;

  // shift the scoreboard one slot older; decode enters slot 0 only when it actually issues
  always_comb begin
    slots_d[0] = (id_valid && !stall && !flush) ?
                 '{valid: 1'b1, reg_write: id_reg_write, is_load: id_mem_read,
                   dest: MAX_ADDR_W'(id_dest)} : '0;
    for (int k = 1; k < DEPTH; k++) slots_d[k] = slots_q[k-1];
  end

  // scoreboard and bubble counter advance only when memory is not back-pressuring
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_q <= '0;
      stall_count_q <= '0;
    end else if (!mem_busy) begin
      slots_q <= slots_d;
      if (stall && stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with a reference slot model for the hazard controller
module tb_pipeline_hazard_ctrl;
  localparam int DW = 16, AW = 3, D = 3, LR = 1, SW = 2;
  localparam bit ZR = 1'b1;

  logic clk = 1'b0, rst = 1'b1;
  logic id_valid, id_reg_write, id_mem_read, id_src1_used, id_src2_used, mem_busy, flush;
  logic [AW-1:0] id_dest, id_src1, id_src2;
  logic [DW-1:0] rf_data1, rf_data2, op1, op2;
  logic [D*DW-1:0] stage_result;
  logic [SW-1:0] fwd_sel1, fwd_sel2;
  logic stall, freeze, kill_id;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .LOAD_READY(LR), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_src1_used(id_src1_used),
    .id_src2_used(id_src2_used), .rf_data1(rf_data1), .rf_data2(rf_data2), .stage_result(stage_result),
    .mem_busy(mem_busy), .flush(flush), .op1(op1), .op2(op2), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall(stall), .freeze(freeze), .kill_id(kill_id), .stall_count(stall_count)
  );

  typedef struct {
    logic [DW-1:0] op1, op2;
    logic [SW-1:0] s1, s2;
    logic st, kl, fz;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];

  logic m_v[D], m_rw[D], m_ld[D];
  logic [AW-1:0] m_d[D];
  logic [15:0] m_cnt;
  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < D; k++) begin
      m_v[k] = 0; m_rw[k] = 0; m_ld[k] = 0; m_d[k] = '0;
    end
    m_cnt = '0;
  endfunction

  function automatic void resolve(input logic used, input logic [AW-1:0] src, input logic [DW-1:0] rf,
                                  output logic [DW-1:0] op, output logic [SW-1:0] sel, output logic hz);
    op = rf; sel = '0; hz = 0;
    if (ZR && src == 0) begin op = '0; return; end
    if (!used) return;
    for (int k = 0; k < D; k++)
      if (m_v[k] && m_rw[k] && m_d[k] == src) begin
        sel = SW'(k+1);
        hz = m_ld[k] && k < LR;
        op = hz ? rf : stage_result[k*DW +: DW];
        return;
      end
  endfunction

  task automatic step();
    exp_t e;
    logic h1, h2;
    resolve(id_src1_used, id_src1, rf_data1, e.op1, e.s1, h1);
    resolve(id_src2_used, id_src2, rf_data2, e.op2, e.s2, h2);
    e.st = id_valid && (h1 || h2) && !flush;
    e.kl = flush;
    e.fz = mem_busy;
    e.cnt = m_cnt;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    check("op1", 32'(op1), 32'(e.op1));
    check("op2", 32'(op2), 32'(e.op2));
    check("fwd_sel1", 32'(fwd_sel1), 32'(e.s1));
    check("fwd_sel2", 32'(fwd_sel2), 32'(e.s2));
    check("stall", 32'(stall), 32'(e.st));
    check("kill_id", 32'(kill_id), 32'(e.kl));
    check("freeze", 32'(freeze), 32'(e.fz));
    check("stall_count", 32'(stall_count), 32'(e.cnt));
    @(posedge clk);
    if (!mem_busy) begin
      for (int k = D-1; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_rw[k] = m_rw[k-1]; m_ld[k] = m_ld[k-1]; m_d[k] = m_d[k-1];
      end
      if (id_valid && !e.st && !flush) begin
        m_v[0] = 1; m_rw[0] = id_reg_write; m_ld[0] = id_mem_read; m_d[0] = id_dest;
      end else begin
        m_v[0] = 0; m_rw[0] = 0; m_ld[0] = 0; m_d[0] = '0;
      end
      if (e.st && m_cnt != 16'hFFFF) m_cnt++;
    end
    #1;
  endtask

  task automatic set_in(input logic v, rw, ld, input logic [AW-1:0] dst, s1, input logic u1,
                        input logic [AW-1:0] s2, input logic u2, input logic busy, fl);
    id_valid = v; id_reg_write = rw; id_mem_read = ld; id_dest = dst;
    id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
    mem_busy = busy; flush = fl;
    rf_data1 = DW'($urandom); rf_data2 = DW'($urandom);
    for (int k = 0; k < D; k++) stage_result[k*DW +: DW] = DW'($urandom);
  endtask

  task automatic drive(input logic v, rw, ld, input logic [AW-1:0] dst, s1, input logic u1,
                       input logic [AW-1:0] s2, input logic u2, input logic busy, fl);
    set_in(v, rw, ld, dst, s1, u1, s2, u2, busy, fl);
    step();
  endtask

  initial begin
    model_clear();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    drive(0, 0, 0, 0, 1, 1, 2, 1, 0, 0);
    // back-to-back ALU forwarding from slot 0
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 3, 1, 4, 1, 0, 0);
    // load-use: one bubble, then forward from slot 1
    drive(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 6, 1, 0, 2, 1, 0, 0);
    drive(1, 1, 0, 6, 1, 0, 2, 1, 0, 0);
    // youngest of two writers to R5 wins
    drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 5, 1, 1, 1, 0, 0);
    // flush overrides a load-use stall
    drive(1, 1, 1, 4, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 7, 4, 1, 0, 0, 0, 1);
    drive(1, 1, 0, 7, 4, 1, 0, 0, 0, 0);
    // freeze holds the scoreboard and counter with a stall pending
    drive(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 6, 2, 1, 0, 0, 1, 0);
    drive(1, 1, 0, 6, 2, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 6, 2, 1, 0, 0, 0, 0);
    // asynchronous reset in the middle of a stall
    drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    set_in(1, 1, 0, 6, 3, 1, 3, 1, 0, 0);
    #2 check("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1;
    model_clear();
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel1", 32'(fwd_sel1), 32'd0);
    check("rst_sel2", 32'(fwd_sel2), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    // register 0 is hardwired: never forwarded, never stalls
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
            1'($urandom_range(0, 3) != 0), AW'($urandom), 1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard controller that sits beside the decode stage of the 16-bit pipelined processor and tracks every instruction issued past decode in a shift-register scoreboard. It forwards the youngest in-flight result to each decode operand, inserts load-use bubbles, discards the decode instruction on a taken branch, and freezes on memory back-pressure. Pipeline depth, data width and register count are generic; the current 5-stage, 8-register, 16-bit core is the default configuration.

## Interface
- DATA_W, 16, operand/result width
- ADDR_W, 3, register-address width (2^ADDR_W registers)
- DEPTH, 3, scoreboard slots tracked past decode (slot 0 = youngest)
- LOAD_READY, 1, first slot index at which load data is valid; 1 ≤ LOAD_READY < DEPTH
- ZERO_REG, 0, 1 = register 0 reads as zero, never forwarded or stalled on
- SEL_W, $clog2(DEPTH+1), forward-select width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_reg_write  in  1  decode instruction writes a register
- id_mem_read  in  1  decode instruction is a load
- id_dest  in  ADDR_W  decode destination
- id_src1, id_src2  in  ADDR_W  decode source registers
- id_src1_used, id_src2_used  in  1  source actually read
- rf_data1, rf_data2  in  DATA_W  register-file read data
- stage_result  in  DEPTH*DATA_W  result of the instruction in slot k at bits [k*DATA_W +: DATA_W]
- mem_busy  in  1  memory stage not ready; whole pipe holds
- flush  in  1  taken branch resolved this cycle
- op1, op2  out  DATA_W  forwarded operands to execute
- fwd_sel1, fwd_sel2  out  SEL_W  0 = register file, k+1 = slot k
- stall  out  1  hold fetch/decode, bubble into slot 0
- freeze  out  1  hold all pipeline registers (= mem_busy)
- kill_id  out  1  discard decode instruction
- stall_count  out  16  saturating count of load-use bubbles

## Operation
- Slot entry: {valid, reg_write, is_load, dest}. Reset: all entries 0; stall_count 0.
- Match on operand n: id_srcn_used, slot valid, reg_write, dest == id_srcn, and not (ZERO_REG and id_srcn == 0). The lowest-index (youngest) matching slot wins.
- Forward: if the winner is slot k, drive fwd_seln = k+1 and opn = stage_result[k]. Otherwise drive fwd_seln = 0 and opn = rf_datan. If ZERO_REG and id_srcn == 0, drive opn = 0 and fwd_seln = 0.
- Load-use: the winner is a load with k < LOAD_READY, and id_valid is high → stall = 1. In this case opn is driven from the register file (don't-care).
- kill_id = flush. flush overrides stall: stall is forced to 0 when flush = 1.
- freeze = mem_busy. All outputs stay combinationally valid during freeze.
- Slot update (edge, when mem_busy = 0):
  - slot[k+1] ← slot[k]; the old slot[DEPTH-1] retires.
  - slot 0 ← decode fields if id_valid, !stall and !flush; otherwise slot 0 ← bubble (all 0).
- mem_busy = 1: the scoreboard and stall_count hold. Stall and forward outputs still evaluate.
- stall_count: increments on edges where stall = 1 and mem_busy = 0. Saturates at 0xFFFF.
- Flush does not kill slots 0..DEPTH-1. Branch resolution lives downstream of them, so older instructions complete.

## Timing
- Scoreboard state is registered. op*, fwd_sel*, stall, kill_id and freeze are combinational from state and inputs: zero-cycle latency.
- A stalled instruction re-evaluates next cycle against a bubble in slot 0. It issues once the load reaches slot LOAD_READY; with the defaults, exactly 1 bubble.
- Simultaneous flush and stall: flush wins, a bubble enters, stall_count does not increment.
- Reset asserted mid-operation: slots clear immediately (async). Outputs fall back to register-file selects with stall = 0. stall_count = 0.
- Two slots with the same dest: the youngest wins; older values are never forwarded.

## Structure
- Package pipe_ctrl_pkg holds:
  - slot_t struct {valid, reg_write, is_load, dest}
  - FWD_RF = 0 constant
  - default DATA_W/ADDR_W localparams shared with decode and execute
- Sub-module fwd_select: priority match plus mux for one operand, instantiated twice. It outputs sel, data and a load_hazard flag.
- The top level holds the slot array, the update logic and the counter.

## Test plan
- Back-to-back ALU: slot 0 = {valid, rw, dest 3}, stage_result[0] = 0x1234, decode src1 = 3 → op1 = 0x1234, fwd_sel1 = 1, stall = 0.
- Load-use: slot 0 = load dest 2, decode src2 = 2 → stall = 1 for one cycle. Next cycle fwd_sel2 = 2, op2 = stage_result[1], stall_count = 1.
- Priority: slot 0 and slot 2 both write R5 with 0xAAAA and 0x5555 → op1 = 0xAAAA, fwd_sel1 = 1.
- Flush during stall: load-use condition with flush = 1 → stall = 0, kill_id = 1, slot 0 becomes a bubble, stall_count unchanged.
- Freeze: mem_busy held 3 cycles → slots and stall_count unchanged, freeze = 1. Release → one shift occurs.
- Reset and ZERO_REG=1: assert rst mid-stall → stall = 0 and all fwd_sel = 0 immediately. src1 = 0 with slot 0 dest 0 → op1 = 0, no stall.
